// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for the pipelined floating-point multiplier.
// The master side is the operand feeder/consumer; the slave side is the multiplier.
interface fp_mul_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         flag_ovf;
   logic         flag_unf;
   logic         flag_inv;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_inv
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, flag_ovf, flag_unf, flag_inv
   );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754-style multiplier.
//   S1: unpack, classify, sign and biased exponent sum; specials resolved here.
//   S2: full mantissa product.
//   S3: normalise, round-to-nearest-even, range check, registered outputs.
// Denormal operands are flushed to zero; results that underflow flush to zero.
// The whole pipe advances together whenever the output slot is free or drained.
module fp_mul_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic        clk,
   input  logic        rst_n,
   fp_mul_pipe_if.slave bus
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int EW2 = EXP_W + 2;
   localparam int PW  = 2 * MAN_W + 2;

   localparam logic signed [EW2-1:0] BIAS_E    = EW2'(2 ** (EXP_W - 1) - 1);
   localparam logic signed [EW2-1:0] EXP_MAX_E = EW2'(2 ** EXP_W - 1);
   localparam logic signed [EW2-1:0] ONE_E     = EW2'(1);
   localparam logic signed [EW2-1:0] ZERO_E    = EW2'(0);

   localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
   localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   // Operand classification helpers
   function automatic logic isZeroF(input logic [EXP_W-1:0] e);
      return (e == {EXP_W{1'b0}});
   endfunction

   function automatic logic isInfF(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
      return (e == EXP_ONES) && (f == {MAN_W{1'b0}});
   endfunction

   function automatic logic isNanF(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
      return (e == EXP_ONES) && (f != {MAN_W{1'b0}});
   endfunction

   logic en_s;

   // Unpacked operand fields
   logic             signA_s, signB_s;
   logic [EXP_W-1:0] expA_s, expB_s;
   logic [MAN_W-1:0] fracA_s, fracB_s;
   logic             nanA_s, nanB_s, infA_s, infB_s, zeroA_s, zeroB_s, infZero_s;
   logic             sign_s;
   logic signed [EW2-1:0] expSum_s;

   // S1 special-case decision
   logic             spec_s;
   logic [W-1:0]     specRes_s;
   logic             specInv_s;

   // Stage 1 registers
   logic                  s1Valid_r;
   logic                  s1Sign_r;
   logic signed [EW2-1:0] s1Exp_r;
   logic [MAN_W:0]        s1ManA_r, s1ManB_r;
   logic                  s1Spec_r;
   logic [W-1:0]          s1SpecRes_r;
   logic                  s1SpecInv_r;

   // Stage 2 registers
   logic                  s2Valid_r;
   logic                  s2Sign_r;
   logic signed [EW2-1:0] s2Exp_r;
   logic [PW-1:0]         s2Prod_r;
   logic                  s2Spec_r;
   logic [W-1:0]          s2SpecRes_r;
   logic                  s2SpecInv_r;

   // Stage 3 combinational datapath
   logic                  normHi_s;
   logic [MAN_W-1:0]      fracPre_s;
   logic                  guard_s, sticky_s, roundUp_s;
   logic signed [EW2-1:0] expNorm_s, expRnd_s;
   logic [MAN_W:0]        fracRnd_s;
   logic [W-1:0]          nextRes_s;
   logic                  nextOvf_s, nextUnf_s, nextInv_s;

   // Output registers
   logic         outValid_r;
   logic [W-1:0] result_r;
   logic         flagOvf_r, flagUnf_r, flagInv_r;

   assign en_s         = ~outValid_r | bus.out_ready;
   assign bus.in_ready = en_s;
   assign bus.out_valid = outValid_r;
   assign bus.result   = result_r;
   assign bus.flag_ovf = flagOvf_r;
   assign bus.flag_unf = flagUnf_r;
   assign bus.flag_inv = flagInv_r;

   assign signA_s = bus.a[W-1];
   assign signB_s = bus.b[W-1];
   assign expA_s  = bus.a[W-2:MAN_W];
   assign expB_s  = bus.b[W-2:MAN_W];
   assign fracA_s = bus.a[MAN_W-1:0];
   assign fracB_s = bus.b[MAN_W-1:0];

   assign nanA_s    = isNanF(expA_s, fracA_s);
   assign nanB_s    = isNanF(expB_s, fracB_s);
   assign infA_s    = isInfF(expA_s, fracA_s);
   assign infB_s    = isInfF(expB_s, fracB_s);
   assign zeroA_s   = isZeroF(expA_s);
   assign zeroB_s   = isZeroF(expB_s);
   assign infZero_s = (infA_s & zeroB_s) | (zeroA_s & infB_s);
   assign sign_s    = signA_s ^ signB_s;
   assign expSum_s  = $signed({2'b00, expA_s}) + $signed({2'b00, expB_s}) - BIAS_E;

   // Resolve special operands by priority: NaN / inf*0, then inf, then zero
   always_comb begin
      spec_s    = 1'b0;
      specRes_s = {W{1'b0}};
      specInv_s = 1'b0;
      if (nanA_s | nanB_s | infZero_s) begin
         spec_s    = 1'b1;
         specRes_s = QNAN;
         specInv_s = infZero_s | (nanA_s & ~fracA_s[MAN_W-1]) | (nanB_s & ~fracB_s[MAN_W-1]);
      end else if (infA_s | infB_s) begin
         spec_s    = 1'b1;
         specRes_s = {sign_s, EXP_ONES, {MAN_W{1'b0}}};
      end else if (zeroA_s | zeroB_s) begin
         spec_s    = 1'b1;
         specRes_s = {sign_s, {(W-1){1'b0}}};
      end else begin
         spec_s    = 1'b0;
      end
   end

   // Stage 1: capture unpacked operands and special-case decision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_r   <= 1'b0;
         s1Sign_r    <= 1'b0;
         s1Exp_r     <= ZERO_E;
         s1ManA_r    <= {(MAN_W+1){1'b0}};
         s1ManB_r    <= {(MAN_W+1){1'b0}};
         s1Spec_r    <= 1'b0;
         s1SpecRes_r <= {W{1'b0}};
         s1SpecInv_r <= 1'b0;
      end else if (en_s) begin
         s1Valid_r   <= bus.in_valid;
         s1Sign_r    <= sign_s;
         s1Exp_r     <= expSum_s;
         s1ManA_r    <= {1'b1, fracA_s};
         s1ManB_r    <= {1'b1, fracB_s};
         s1Spec_r    <= spec_s;
         s1SpecRes_r <= specRes_s;
         s1SpecInv_r <= specInv_s;
      end
   end

   // Stage 2: full-width mantissa product
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2Valid_r   <= 1'b0;
         s2Sign_r    <= 1'b0;
         s2Exp_r     <= ZERO_E;
         s2Prod_r    <= {PW{1'b0}};
         s2Spec_r    <= 1'b0;
         s2SpecRes_r <= {W{1'b0}};
         s2SpecInv_r <= 1'b0;
      end else if (en_s) begin
         s2Valid_r   <= s1Valid_r;
         s2Sign_r    <= s1Sign_r;
         s2Exp_r     <= s1Exp_r;
         s2Prod_r    <= PW'(s1ManA_r) * PW'(s1ManB_r);
         s2Spec_r    <= s1Spec_r;
         s2SpecRes_r <= s1SpecRes_r;
         s2SpecInv_r <= s1SpecInv_r;
      end
   end

   // Stage 3 datapath: normalise the product, round to nearest even, range check
   always_comb begin
      normHi_s = s2Prod_r[PW-1];
      if (normHi_s) begin
         fracPre_s = s2Prod_r[2*MAN_W -: MAN_W];
         guard_s   = s2Prod_r[MAN_W];
         sticky_s  = |s2Prod_r[MAN_W-1:0];
         expNorm_s = s2Exp_r + ONE_E;
      end else begin
         fracPre_s = s2Prod_r[2*MAN_W-1 -: MAN_W];
         guard_s   = s2Prod_r[MAN_W-1];
         sticky_s  = |s2Prod_r[MAN_W-2:0];
         expNorm_s = s2Exp_r;
      end
      roundUp_s = guard_s & (sticky_s | fracPre_s[0]);
      fracRnd_s = {1'b0, fracPre_s} + {{MAN_W{1'b0}}, roundUp_s};
      // A carry out of the fraction leaves frac=0 and bumps the exponent
      if (fracRnd_s[MAN_W]) begin
         expRnd_s = expNorm_s + ONE_E;
      end else begin
         expRnd_s = expNorm_s;
      end

      nextRes_s = {s2Sign_r, expRnd_s[EXP_W-1:0], fracRnd_s[MAN_W-1:0]};
      nextOvf_s = 1'b0;
      nextUnf_s = 1'b0;
      nextInv_s = 1'b0;
      if (s2Spec_r) begin
         nextRes_s = s2SpecRes_r;
         nextInv_s = s2SpecInv_r;
      end else if (expRnd_s >= EXP_MAX_E) begin
         nextRes_s = {s2Sign_r, EXP_ONES, {MAN_W{1'b0}}};
         nextOvf_s = 1'b1;
      end else if (expRnd_s <= ZERO_E) begin
         nextRes_s = {s2Sign_r, {(W-1){1'b0}}};
         nextUnf_s = 1'b1;
      end else begin
         nextInv_s = 1'b0;
      end
   end

   // Stage 3: registered result and flags, held stable while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid_r <= 1'b0;
         result_r   <= {W{1'b0}};
         flagOvf_r  <= 1'b0;
         flagUnf_r  <= 1'b0;
         flagInv_r  <= 1'b0;
      end else if (en_s) begin
         outValid_r <= s2Valid_r;
         if (s2Valid_r) begin
            result_r  <= nextRes_s;
            flagOvf_r <= nextOvf_s;
            flagUnf_r <= nextUnf_s;
            flagInv_r <= nextInv_s;
         end else begin
            result_r  <= result_r;
            flagOvf_r <= flagOvf_r;
            flagUnf_r <= flagUnf_r;
            flagInv_r <= flagInv_r;
         end
      end
   end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (single-precision configuration).
// Directed vector table, stall/reset sequences, and a randomized stream
// scored against an exact-arithmetic reference model.
module tb_fp_mul_pipe;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fp_mul_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

   fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [31:0] res;
      logic        ovf;
      logic        unf;
      logic        inv;
   } out_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [2:0]  flg;   // {ovf, unf, inv}
   } vec_t;

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   out_t expQ[$];

   logic        acc;
   logic        dlv;
   logic [31:0] dres;
   logic [2:0]  dflg;

   vec_t tbl[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Exact reference: integer mantissa product rounded by remainder comparison.
   function automatic out_t refMul(input logic [31:0] a, input logic [31:0] b);
      out_t r;
      logic s, nanA, nanB, infA, infB, zA, zB;
      int ea, eb, e, msb, sh;
      longint unsigned fa, fb, p, q, rem, half;
      r  = '0;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      fa = 64'(a[22:0]);
      fb = 64'(b[22:0]);
      nanA = (ea == 255) && (fa != 0);
      nanB = (eb == 255) && (fb != 0);
      infA = (ea == 255) && (fa == 0);
      infB = (eb == 255) && (fb == 0);
      zA   = (ea == 0);
      zB   = (eb == 0);
      if (nanA || nanB || (infA && zB) || (zA && infB)) begin
         r.res = 32'h7FC00000;
         r.inv = (infA && zB) || (zA && infB) || (nanA && !a[22]) || (nanB && !b[22]);
      end else if (infA || infB) begin
         r.res = {s, 8'hFF, 23'd0};
      end else if (zA || zB) begin
         r.res = {s, 31'd0};
      end else begin
         p = (fa + 64'd8388608) * (fb + 64'd8388608);
         msb = 0;
         for (int i = 0; i < 64; i++) if (p[i]) msb = i;
         e    = ea + eb - 127 + (msb - 46);
         sh   = msb - 23;
         q    = p >> sh;
         rem  = p - (q << sh);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 64'd1;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
         end
         if (e >= 255) begin
            r.res = {s, 8'hFF, 23'd0};
            r.ovf = 1'b1;
         end else if (e <= 0) begin
            r.res = {s, 31'd0};
            r.unf = 1'b1;
         end else begin
            r.res = {s, 8'(e), 23'(q)};
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] randOp();
      int          k;
      logic        s;
      logic [7:0]  e;
      logic [22:0] f;
      k = $urandom_range(0, 19);
      s = 1'($urandom_range(0, 1));
      f = 23'($urandom);
      case (k)
         0:       e = 8'd0;
         1:       begin e = 8'hFF; f = 23'd0; end
         2:       begin e = 8'hFF; if (f == 23'd0) f = 23'd1; end
         3:       e = 8'($urandom_range(1, 254));
         4:       e = 8'($urandom_range(1, 30));
         default: e = 8'($urandom_range(64, 190));
      endcase
      return {s, e, f};
   endfunction

   // One clock cycle: drive at the falling edge, observe the handshake, score.
   task automatic doCycle(input logic iv, input logic [31:0] av, input logic [31:0] bv,
                          input logic ordy);
      out_t e;
      @(negedge clk);
      bus.in_valid  = iv;
      bus.a         = av;
      bus.b         = bv;
      bus.out_ready = ordy;
      #1;
      acc  = iv && bus.in_ready;
      dlv  = bus.out_valid && ordy;
      dres = bus.result;
      dflg = {bus.flag_ovf, bus.flag_unf, bus.flag_inv};
      if (dlv) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_output: got %h with nothing outstanding (t=%0t)", dres, $time);
         end else begin
            e = expQ.pop_front();
            check("sb_result", dres, e.res);
            check("sb_flags", {29'd0, dflg}, {29'd0, e.ovf, e.unf, e.inv});
         end
      end
      if (acc) expQ.push_back(refMul(av, bv));
      cyc++;
   endtask

   task automatic sendAndCheck(input vec_t v, input string name);
      int   accC;
      logic got;
      got = 1'b0;
      doCycle(1'b1, v.a, v.b, 1'b1);
      check({name, "_accept"}, {31'd0, acc}, 32'd1);
      accC = cyc - 1;
      for (int k = 0; k < 10 && !got; k++) begin
         doCycle(1'b0, 32'd0, 32'd0, 1'b1);
         if (dlv) begin
            got = 1'b1;
            check({name, "_latency"}, 32'(cyc - 1 - accC), 32'd3);
            check({name, "_result"}, dres, v.res);
            check({name, "_flags"}, {29'd0, dflg}, {29'd0, v.flg});
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no out_valid, required one within 10 cycles", name);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          sent, d, first, last;
      logic        seen, pend;
      logic [31:0] holdRes, ra, rb;
      logic [2:0]  holdFlg;

      tbl[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000};
      tbl[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000};
      tbl[2]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000};
      tbl[3]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000};
      tbl[4]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100};
      tbl[5]  = '{32'h00800000, 32'h00800000, 32'h00000000, 3'b010};
      tbl[6]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001};
      tbl[7]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000};
      tbl[8]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b000};
      tbl[9]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b001};
      tbl[10] = '{32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 3'b000};
      tbl[11] = '{32'h80000000, 32'h40000000, 32'h80000000, 3'b000};

      bus.in_valid  = 1'b0;
      bus.a         = 32'd0;
      bus.b         = 32'd0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b1;
      #1 rst_n      = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset_result", bus.result, 32'd0);
      check("reset_flags", {29'd0, bus.flag_ovf, bus.flag_unf, bus.flag_inv}, 32'd0);
      check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, one at a time with a free-running consumer
      for (int i = 0; i < 12; i++) sendAndCheck(tbl[i], $sformatf("vec%0d", i));

      // Back-to-back stream of 8 pairs: 8 consecutive deliveries in order
      d = 0; first = -1; last = -1;
      for (int i = 0; i < 30 && d < 8; i++) begin
         if (i < 8) doCycle(1'b1, randOp(), randOp(), 1'b1);
         else doCycle(1'b0, 32'd0, 32'd0, 1'b1);
         if (dlv) begin
            if (first < 0) first = cyc;
            last = cyc;
            d++;
         end
      end
      check("stream_count", 32'(d), 32'd8);
      check("stream_consecutive", 32'(last - first), 32'd7);

      // Backpressure: consumer stalled while 4 pairs are offered
      sent = 0; seen = 1'b0; holdRes = 32'd0; holdFlg = 3'd0;
      for (int i = 0; i < 10; i++) begin
         doCycle(sent < 4, tbl[(sent < 4) ? sent : 0].a, tbl[(sent < 4) ? sent : 0].b, 1'b0);
         if (acc) sent++;
         if (bus.out_valid) begin
            if (!seen) begin
               seen    = 1'b1;
               holdRes = dres;
               holdFlg = dflg;
               check("stall_first_result", holdRes, tbl[0].res);
            end else begin
               check("stall_result_stable", dres, holdRes);
               check("stall_flags_stable", {29'd0, dflg}, {29'd0, holdFlg});
            end
         end
      end
      check("stall_accepted", 32'(sent), 32'd3);
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      d = 0;
      for (int i = 0; i < 20 && d < 4; i++) begin
         doCycle(sent < 4, tbl[(sent < 4) ? sent : 0].a, tbl[(sent < 4) ? sent : 0].b, 1'b1);
         if (acc) sent++;
         if (dlv) d++;
      end
      check("release_delivered", 32'(d), 32'd4);
      check("release_accepted", 32'(sent), 32'd4);

      // Asynchronous reset with three operations in flight
      for (int i = 0; i < 3; i++) doCycle(1'b1, tbl[i].a, tbl[i].b, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("pre_reset_out_valid", {31'd0, bus.out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midreset_flags", {29'd0, bus.flag_ovf, bus.flag_unf, bus.flag_inv}, 32'd0);
      check("midreset_result", bus.result, 32'd0);
      expQ.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      d = 0;
      for (int i = 0; i < 8; i++) begin
         doCycle(1'b0, 32'd0, 32'd0, 1'b1);
         if (bus.out_valid) d++;
      end
      check("post_reset_no_stale", 32'(d), 32'd0);
      sendAndCheck(tbl[0], "post_reset");

      // Randomized traffic with random stalls, scored against the model
      pend = 1'b0; ra = 32'd0; rb = 32'd0;
      for (int i = 0; i < 400; i++) begin
         if (!pend) begin
            ra   = randOp();
            rb   = randOp();
            pend = ($urandom_range(0, 9) < 7);
         end
         doCycle(pend, ra, rb, $urandom_range(0, 9) < 7);
         if (acc) pend = 1'b0;
      end
      for (int i = 0; i < 30 && expQ.size() != 0; i++) doCycle(1'b0, 32'd0, 32'd0, 1'b1);
      check("random_drained", 32'(expQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
